// File: rtl/if_fetch_ctrl_if.sv
// Instruction-memory request/response bundle between the fetch controller
// and the instruction memory. The controller is the master (issues req/addr),
// the memory is the slave (returns ready, rvalid and rdata).
interface if_fetch_ctrl_if #(
    parameter int XLEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ready;
    logic            imem_rvalid;
    logic [31:0]     imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller. Fetches the instruction at the current PC,
// loads the IF/ID pipeline register, steers the PC register (hold / next PC /
// redirect), parks a response in a one-entry skid buffer while decode is
// stalled, and drops responses that became stale because of a redirect.
module if_fetch_ctrl #(
    parameter int          XLEN      = 32,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    parameter int          CNT_W     = 32
) (
    input  logic             clk,
    input  logic             srst,
    input  logic [XLEN-1:0]  pc,
    output logic [XLEN-1:0]  pc_next,
    output logic             stall_f,
    input  logic             stall_d,
    input  logic             pc_src_e,
    input  logic [XLEN-1:0]  pc_target_e,
    if_fetch_ctrl_if.master  imem,
    output logic [31:0]      instr_d,
    output logic [XLEN-1:0]  pc_d,
    output logic [XLEN-1:0]  pc_plus4_d,
    output logic             valid_d,
    output logic [CNT_W-1:0] fetch_cnt
);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam logic [XLEN-1:0]  PC_INC  = XLEN'(32'd4);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(32'd1);

    state_t            state_r;
    state_t            state_s;

    // skid buffer: one parked response while decode is stalled
    logic              skid_valid_r;
    logic [31:0]       skid_instr_r;
    logic [XLEN-1:0]   skid_pc_r;

    // IF/ID pipeline register
    logic              valid_d_r;
    logic [31:0]       instr_d_r;
    logic [XLEN-1:0]   pc_d_r;
    logic [XLEN-1:0]   pc_plus4_d_r;
    logic [CNT_W-1:0]  fetch_cnt_r;

    // per-cycle decisions
    logic              load_s;
    logic [31:0]       load_instr_s;
    logic [XLEN-1:0]   load_pc_s;
    logic              skid_cap_s;
    logic              stall_f_s;
    logic              imem_req_s;

    assign imem.imem_req  = imem_req_s;
    assign imem.imem_addr = pc;
    assign stall_f        = stall_f_s;
    assign pc_next        = pc_src_e ? pc_target_e : (pc + PC_INC);

    assign valid_d    = valid_d_r;
    assign instr_d    = instr_d_r;
    assign pc_d       = pc_d_r;
    assign pc_plus4_d = pc_plus4_d_r;
    assign fetch_cnt  = fetch_cnt_r;

    // State register: fetch FSM state, async reset to FETCH
    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            state_r <= ST_FETCH;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic: a redirect drains only when a request is still in flight
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_FETCH: begin
                if (imem.imem_ready) begin
                    state_s = pc_src_e ? ST_DRAIN : ST_WAIT;
                end else begin
                    state_s = ST_FETCH;
                end
            end
            ST_WAIT: begin
                if (pc_src_e) begin
                    state_s = imem.imem_rvalid ? ST_FETCH : ST_DRAIN;
                end else if (imem.imem_rvalid) begin
                    state_s = stall_d ? ST_HOLD : ST_FETCH;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_HOLD: begin
                if (pc_src_e || !stall_d) begin
                    state_s = ST_FETCH;
                end else begin
                    state_s = ST_HOLD;
                end
            end
            ST_DRAIN: begin
                if (imem.imem_rvalid) begin
                    state_s = ST_FETCH;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            default: state_s = ST_FETCH;
        endcase
    end

    // Output logic: pick the IF/ID load source and release the PC only on hand-off or redirect
    always_comb begin
        load_s       = 1'b0;
        load_instr_s = NOP_INSTR;
        load_pc_s    = {XLEN{1'b0}};
        skid_cap_s   = 1'b0;
        imem_req_s   = 1'b0;
        case (state_r)
            ST_FETCH: begin
                imem_req_s = 1'b1;
            end
            ST_WAIT: begin
                if (imem.imem_rvalid && !pc_src_e) begin
                    if (stall_d) begin
                        skid_cap_s = 1'b1;
                    end else begin
                        load_s       = 1'b1;
                        load_instr_s = imem.imem_rdata;
                        load_pc_s    = pc;
                    end
                end else begin
                    load_s = 1'b0;
                end
            end
            ST_HOLD: begin
                if (skid_valid_r && !stall_d && !pc_src_e) begin
                    load_s       = 1'b1;
                    load_instr_s = skid_instr_r;
                    load_pc_s    = skid_pc_r;
                end else begin
                    load_s = 1'b0;
                end
            end
            default: begin
                load_s = 1'b0;
            end
        endcase
        stall_f_s = ~(load_s | pc_src_e);
    end

    // Skid buffer: park a response that arrives under a decode stall, drop it on redirect or use
    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            skid_valid_r <= 1'b0;
            skid_instr_r <= NOP_INSTR;
            skid_pc_r    <= {XLEN{1'b0}};
        end else if (pc_src_e) begin
            skid_valid_r <= 1'b0;
        end else if (skid_cap_s) begin
            skid_valid_r <= 1'b1;
            skid_instr_r <= imem.imem_rdata;
            skid_pc_r    <= pc;
        end else if (load_s) begin
            skid_valid_r <= 1'b0;
        end else begin
            skid_valid_r <= skid_valid_r;
        end
    end

    // IF/ID register: flush beats stall, stall holds, otherwise load or insert a bubble
    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            valid_d_r    <= 1'b0;
            instr_d_r    <= NOP_INSTR;
            pc_d_r       <= {XLEN{1'b0}};
            pc_plus4_d_r <= {XLEN{1'b0}};
        end else if (pc_src_e) begin
            valid_d_r <= 1'b0;
            instr_d_r <= NOP_INSTR;
        end else if (load_s) begin
            valid_d_r    <= 1'b1;
            instr_d_r    <= load_instr_s;
            pc_d_r       <= load_pc_s;
            pc_plus4_d_r <= load_pc_s + PC_INC;
        end else if (!stall_d) begin
            valid_d_r <= 1'b0;
            instr_d_r <= NOP_INSTR;
        end else begin
            valid_d_r <= valid_d_r;
        end
    end

    // Delivered-instruction counter, saturating at all-ones
    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            fetch_cnt_r <= {CNT_W{1'b0}};
        end else if (load_s && (fetch_cnt_r != CNT_MAX)) begin
            fetch_cnt_r <= fetch_cnt_r + CNT_ONE;
        end else begin
            fetch_cnt_r <= fetch_cnt_r;
        end
    end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed testbench for if_fetch_ctrl: linear sequence of steps with
// hand-computed expected values checked by immediate assertions.
module tb_if_fetch_ctrl;

    logic        clk;
    logic        srst;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic        stall_f;
    logic        stall_d;
    logic        pc_src_e;
    logic [31:0] pc_target_e;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pc_plus4_d;
    logic        valid_d;
    logic [31:0] fetch_cnt;

    int checks = 0;
    int errors = 0;

    if_fetch_ctrl_if #(.XLEN(32)) bus ();

    if_fetch_ctrl #(
        .XLEN(32),
        .NOP_INSTR(32'h0000_0013),
        .CNT_W(32)
    ) dut (
        .clk        (clk),
        .srst       (srst),
        .pc         (pc),
        .pc_next    (pc_next),
        .stall_f    (stall_f),
        .stall_d    (stall_d),
        .pc_src_e   (pc_src_e),
        .pc_target_e(pc_target_e),
        .imem       (bus.master),
        .instr_d    (instr_d),
        .pc_d       (pc_d),
        .pc_plus4_d (pc_plus4_d),
        .valid_d    (valid_d),
        .fetch_cnt  (fetch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        srst            = 1'b1;
        pc              = 32'h0000_0100;
        stall_d         = 1'b0;
        pc_src_e        = 1'b0;
        pc_target_e     = 32'h0;
        bus.imem_ready  = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0;

        // reset state
        #12;
        check("rst_valid", valid_d, 1'b0);
        check("rst_instr", instr_d, 32'h13);
        check("rst_pc_d", pc_d, 32'h0);
        check("rst_pc4_d", pc_plus4_d, 32'h0);
        check("rst_cnt", fetch_cnt, 32'h0);
        check("rst_state", dut.state_r, 2'd0);
        srst = 1'b0;

        // normal fetch at 0x100
        bus.imem_ready = 1'b1;
        #1;
        check("f1_req", bus.imem_req, 1'b1);
        check("f1_addr", bus.imem_addr, 32'h100);
        check("f1_stall_f_req", stall_f, 1'b1);
        check("f1_pc_next", pc_next, 32'h104);
        tick();
        check("f1_state_wait", dut.state_r, 2'd1);
        check("f1_req_wait", bus.imem_req, 1'b0);
        bus.imem_ready  = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'h0050_0093;
        #1;
        check("f1_stall_f_rv", stall_f, 1'b0);
        tick();
        check("f1_instr", instr_d, 32'h0050_0093);
        check("f1_pc_d", pc_d, 32'h100);
        check("f1_pc4_d", pc_plus4_d, 32'h104);
        check("f1_valid", valid_d, 1'b1);
        check("f1_cnt", fetch_cnt, 32'd1);
        check("f1_state_fetch", dut.state_r, 2'd0);

        // decode stall: response parked in skid buffer for 3 stalled cycles
        pc              = 32'h0000_0104;
        bus.imem_rvalid = 1'b0;
        bus.imem_ready  = 1'b1;
        stall_d         = 1'b1;
        tick();
        check("s_hold_fetch_valid", valid_d, 1'b1);
        bus.imem_ready  = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'h00A0_0113;
        #1;
        check("s_stall_f_0", stall_f, 1'b1);
        tick();
        check("s_state_hold", dut.state_r, 2'd2);
        bus.imem_rvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            check("s_stall_f_n", stall_f, 1'b1);
            tick();
            check("s_instr_held", instr_d, 32'h0050_0093);
            check("s_pc_held", pc_d, 32'h100);
            check("s_valid_held", valid_d, 1'b1);
        end
        stall_d = 1'b0;
        #1;
        check("s_stall_f_rel", stall_f, 1'b0);
        check("s_pc_next", pc_next, 32'h108);
        tick();
        check("s_instr", instr_d, 32'h00A0_0113);
        check("s_pc_d", pc_d, 32'h104);
        check("s_pc4_d", pc_plus4_d, 32'h108);
        check("s_valid", valid_d, 1'b1);
        check("s_cnt", fetch_cnt, 32'd2);
        check("s_state_fetch", dut.state_r, 2'd0);

        // redirect in WAIT without rvalid -> DRAIN, stale response dropped
        pc             = 32'h0000_0108;
        bus.imem_ready = 1'b1;
        tick();
        check("r_bubble_valid", valid_d, 1'b0);
        check("r_bubble_instr", instr_d, 32'h13);
        bus.imem_ready = 1'b0;
        pc_src_e       = 1'b1;
        pc_target_e    = 32'h0000_0200;
        #1;
        check("r_stall_f", stall_f, 1'b0);
        check("r_pc_next", pc_next, 32'h200);
        tick();
        check("r_state_drain", dut.state_r, 2'd3);
        check("r_valid", valid_d, 1'b0);
        pc_src_e        = 1'b0;
        pc              = 32'h0000_0200;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'hDEAD_BEEF;
        #1;
        check("r_drain_req", bus.imem_req, 1'b0);
        check("r_drain_stall_f", stall_f, 1'b1);
        tick();
        check("r_drop_valid", valid_d, 1'b0);
        check("r_drop_instr", instr_d, 32'h13);
        check("r_drop_cnt", fetch_cnt, 32'd2);
        check("r_state_fetch", dut.state_r, 2'd0);
        bus.imem_rvalid = 1'b0;
        bus.imem_ready  = 1'b1;
        #1;
        check("r_new_req", bus.imem_req, 1'b1);
        check("r_new_addr", bus.imem_addr, 32'h200);
        tick();
        bus.imem_ready  = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'h0030_0193;
        tick();
        check("r_tgt_instr", instr_d, 32'h0030_0193);
        check("r_tgt_pc_d", pc_d, 32'h200);
        check("r_tgt_cnt", fetch_cnt, 32'd3);

        // redirect together with stall_d in HOLD -> flush wins
        pc              = 32'h0000_0204;
        bus.imem_rvalid = 1'b0;
        bus.imem_ready  = 1'b1;
        stall_d         = 1'b1;
        tick();
        bus.imem_ready  = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'h0040_0213;
        tick();
        check("h_state_hold", dut.state_r, 2'd2);
        bus.imem_rvalid = 1'b0;
        pc_src_e        = 1'b1;
        pc_target_e     = 32'h0000_0300;
        #1;
        check("h_stall_f", stall_f, 1'b0);
        tick();
        check("h_valid", valid_d, 1'b0);
        check("h_instr", instr_d, 32'h13);
        check("h_state_fetch", dut.state_r, 2'd0);
        check("h_skid_dropped", dut.skid_valid_r, 1'b0);
        pc_src_e = 1'b0;
        stall_d  = 1'b0;
        pc       = 32'h0000_0300;
        tick();
        check("h_no_load_valid", valid_d, 1'b0);
        check("h_no_load_cnt", fetch_cnt, 32'd3);

        // redirect in FETCH with an accepted request -> DRAIN
        bus.imem_ready = 1'b1;
        pc_src_e       = 1'b1;
        pc_target_e    = 32'h0000_0500;
        tick();
        check("fr_state_drain", dut.state_r, 2'd3);
        pc_src_e        = 1'b0;
        pc              = 32'h0000_0500;
        bus.imem_ready  = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'h0BAD_0BAD;
        tick();
        check("fr_state_fetch", dut.state_r, 2'd0);
        check("fr_valid", valid_d, 1'b0);
        bus.imem_rvalid = 1'b0;

        // PC wrap and counter saturation
        pc = 32'hFFFF_FFFC;
        force dut.fetch_cnt_r = 32'hFFFF_FFFF;
        #1;
        release dut.fetch_cnt_r;
        check("w_pc_next", pc_next, 32'h0);
        check("w_cnt_pre", fetch_cnt, 32'hFFFF_FFFF);
        bus.imem_ready = 1'b1;
        tick();
        bus.imem_ready  = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'h0010_0073;
        tick();
        check("w_pc_d", pc_d, 32'hFFFF_FFFC);
        check("w_pc4_d", pc_plus4_d, 32'h0);
        check("w_valid", valid_d, 1'b1);
        check("w_cnt_sat", fetch_cnt, 32'hFFFF_FFFF);

        // async reset in the middle of WAIT
        pc              = 32'h0000_0400;
        bus.imem_rvalid = 1'b0;
        bus.imem_ready  = 1'b1;
        stall_d         = 1'b1;
        tick();
        check("a_state_wait", dut.state_r, 2'd1);
        check("a_valid_pre", valid_d, 1'b1);
        bus.imem_ready = 1'b0;
        #2;
        srst = 1'b1;
        #1;
        check("a_valid", valid_d, 1'b0);
        check("a_instr", instr_d, 32'h13);
        check("a_state", dut.state_r, 2'd0);
        check("a_cnt", fetch_cnt, 32'h0);
        #1;
        srst            = 1'b0;
        stall_d         = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'h1111_1111;
        tick();
        check("a_stray_valid", valid_d, 1'b0);
        check("a_stray_cnt", fetch_cnt, 32'h0);
        check("a_stray_state", dut.state_r, 2'd0);
        bus.imem_rvalid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_fetch_ctrl.md
Name: if_fetch_ctrl

Overview:
Instruction-fetch controller directly downstream of the program counter register. It fetches the instruction at the current PC over a req/ready + rvalid instruction-memory interface, then loads the IF/ID pipeline register (instr, pc, pc+4, valid). It drives the PC register's hold input (stall_f) and its next-PC value, including the taken-branch/jump redirect from EX. It absorbs decode stalls with a one-entry skid buffer and discards stale responses after a redirect.

Parameters:
XLEN, 32, address/data width (only 32 supported)
NOP_INSTR, 32'h0000_0013, instruction placed in instr_d for bubbles (addi x0,x0,0)
CNT_W, 32, width of fetched-instruction counter

Ports:
clk  in  1  clock, all state on rising edge
srst  in  1  reset, asynchronous, active-high
pc  in  XLEN  current PC from PC register
pc_next  out  XLEN  next PC to PC register
stall_f  out  1  to PC register enable; 1 = hold PC, 0 = load pc_next
stall_d  in  1  decode stall from hazard unit; IF/ID must hold
pc_src_e  in  1  taken branch/jump in EX (redirect + flush)
pc_target_e  in  XLEN  redirect target
imem_req  out  1  request valid
imem_addr  out  XLEN  request address
imem_ready  in  1  request accepted this cycle (req&ready)
imem_rvalid  in  1  response valid (one per accepted request)
imem_rdata  in  32  response instruction
instr_d  out  32  IF/ID instruction
pc_d  out  XLEN  IF/ID PC
pc_plus4_d  out  XLEN  IF/ID PC+4
valid_d  out  1  IF/ID valid
fetch_cnt  out  CNT_W  instructions delivered to IF/ID, saturating

Behaviour:
- Reset (async, srst=1): state=FETCH; valid_d=0, instr_d=NOP_INSTR, pc_d=0, pc_plus4_d=0, skid buffer cleared, fetch_cnt=0. Outputs reflect reset immediately, not at the next edge.
- Combinational next PC: pc_next = pc_src_e ? pc_target_e : pc+4, with 32-bit wrap (0xFFFF_FFFC+4 = 0).
- imem_req=1 only in FETCH. imem_addr=pc. An un-accepted request may be withdrawn. At most one request is outstanding.
- FETCH: if imem_ready, go to WAIT. An imem_rvalid seen in FETCH is ignored.
- WAIT: on rvalid with !stall_d, load IF/ID {rdata, pc, pc+4, 1}, stall_f=0, and go to FETCH. On rvalid with stall_d, capture {rdata, pc} into the skid buffer and go to HOLD.
- HOLD: IF/ID is held. When !stall_d, load IF/ID from the buffer, stall_f=0, and go to FETCH.
- DRAIN (stale request outstanding): wait for rvalid, discard the data, then go to FETCH.
- stall_f=0 only in these cycles: an instruction is handed to IF/ID, or pc_src_e=1. In all other cycles stall_f=1.
- Redirect (pc_src_e=1) in any state: stall_f=0, so the PC loads pc_target_e. IF/ID is flushed (valid_d<=0, instr_d<=NOP_INSTR); the flush overrides stall_d. Skid buffer is invalidated. Next state:
  - FETCH with imem_ready=1 → DRAIN.
  - FETCH with imem_ready=0 → FETCH.
  - WAIT without rvalid → DRAIN.
  - WAIT with rvalid → FETCH (data dropped).
  - HOLD → FETCH.
  - DRAIN without rvalid → DRAIN.
  - DRAIN with rvalid → FETCH.
- Bubble: with !stall_d, no redirect, and no instruction loaded this cycle, IF/ID is cleared (valid_d<=0, instr_d<=NOP_INSTR). With stall_d, IF/ID holds all fields.
- fetch_cnt increments by 1 per IF/ID load with valid=1. It saturates at all-ones.
- Throughput with imem_ready=1 and 1-cycle rvalid: one instruction per 2 cycles. The request at cycle N gives IF/ID valid at edge N+2.

Test Plan:
- Reset mid-WAIT (assert srst asynchronously) → outputs clear immediately: valid_d=0, instr_d=0x13, state FETCH; a later stray rvalid is ignored and fetch_cnt stays 0.
- pc=0x100, ready=1, rvalid next cycle with rdata=0x00500093, stall_d=0 → after 2 edges: instr_d=0x00500093, pc_d=0x100, pc_plus4_d=0x104, valid_d=1; stall_f=0 in the rvalid cycle; fetch_cnt=1.
- rvalid arrives with stall_d=1 held for 3 cycles → IF/ID unchanged and stall_f=1 throughout; the first !stall_d cycle loads the buffered instruction and stall_f=0.
- pc_src_e=1, target 0x200, in WAIT without rvalid → stall_f=0, valid_d=0, state DRAIN; the next rvalid (0xDEADBEEF) is discarded; the following request has imem_addr=0x200.
- pc_src_e=1 together with stall_d=1 in HOLD → valid_d=0 (flush wins), buffer dropped, state FETCH.
- pc=0xFFFF_FFFC fetch, and fetch_cnt preloaded to the all-ones value via force → pc_plus4_d=0 and pc_next=0; fetch_cnt stays at the all-ones value.
